move_scheduler: RTL and testbench

Game-tick controller between the keypad direction path and the snake body/position logic. It generates the periodic move strobe at a selectable speed and buffers up to two pending turns, so fast key sequences (e.g. RIGHT then DOWN within one tick) are not lost. It filters illegal 180° turns against the most recent pending direction and sequences the game states IDLE / RUN / PAUSE / HALT.

---
 rtl/move_scheduler_if.sv | 25 ++
 rtl/move_scheduler.sv | 135 +++++++++++++
 tb/tb_move_scheduler.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/move_scheduler_if.sv
// Control/status bundle between the keypad/game-control side and the move scheduler.
// master drives requests and control strobes; slave (the scheduler) returns tick and status.
interface move_scheduler_if;
  logic [1:0] dir_req;
  logic       dir_req_valid;
  logic       start;
  logic       pause_toggle;
  logic       game_over;
  logic [1:0] speed;
  logic       move_tick;
  logic [1:0] move_dir;
  logic [1:0] queue_count;
  logic       dropped;
  logic [1:0] state_o;

  modport master (
    output dir_req, dir_req_valid, start, pause_toggle, game_over, speed,
    input  move_tick, move_dir, queue_count, dropped, state_o
  );

  modport slave (
    input  dir_req, dir_req_valid, start, pause_toggle, game_over, speed,
    output move_tick, move_dir, queue_count, dropped, state_o
  );
endinterface

// File: rtl/move_scheduler.sv
// Game-tick controller: periodic move strobe at a latched speed, a two-deep turn queue
// with reverse/full filtering, and the IDLE/RUN/PAUSE/HALT game state machine.
module move_scheduler #(
  parameter int unsigned TICK_BASE = 2500000,
  parameter int unsigned TICK_STEP = 500000,
  parameter int unsigned CNT_W     = 22
) (
  input  logic                clk,
  input  logic                rstn,
  move_scheduler_if.slave     bus
);

  localparam logic [CNT_W-1:0] LAST_S0 = CNT_W'(TICK_BASE - 1);
  localparam logic [CNT_W-1:0] LAST_S1 = CNT_W'(TICK_BASE - TICK_STEP - 1);
  localparam logic [CNT_W-1:0] LAST_S2 = CNT_W'(TICK_BASE - 2 * TICK_STEP - 1);
  localparam logic [CNT_W-1:0] LAST_S3 = CNT_W'(TICK_BASE - 3 * TICK_STEP - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_HALT  = 2'b11
  } state_t;

  state_t           r_state, w_state_n;
  logic [CNT_W-1:0] r_cnt,   w_cnt_n;
  logic [1:0]       r_spd,   w_spd_n;
  logic [1:0]       r_dir,   w_dir_n;
  logic [1:0]       r_q0,    w_q0_n;
  logic [1:0]       r_q1,    w_q1_n;
  logic [1:0]       r_count, w_count_n;
  logic             r_tick,  w_tick_n;
  logic             r_drop,  w_drop_n;
  logic [CNT_W-1:0] w_last;
  logic [1:0]       w_ref;

  // Last counter value of the current period, from the speed latched at the previous tick
  always_comb begin
    case (r_spd)
      2'd0:    w_last = LAST_S0;
      2'd1:    w_last = LAST_S1;
      2'd2:    w_last = LAST_S2;
      default: w_last = LAST_S3;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_spd   <= 2'd0;
      r_dir   <= 2'd0;
      r_q0    <= 2'd0;
      r_q1    <= 2'd0;
      r_count <= 2'd0;
      r_tick  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_spd   <= w_spd_n;
      r_dir   <= w_dir_n;
      r_q0    <= w_q0_n;
      r_q1    <= w_q1_n;
      r_count <= w_count_n;
      r_tick  <= w_tick_n;
      r_drop  <= w_drop_n;
    end
  end

  // Control strobes take the whole cycle; only a plain RUN cycle counts, pops and accepts turns
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_spd_n   = r_spd;
    w_dir_n   = r_dir;
    w_q0_n    = r_q0;
    w_q1_n    = r_q1;
    w_count_n = r_count;
    w_tick_n  = 1'b0;
    w_drop_n  = 1'b0;
    w_ref     = r_dir;

    if (bus.game_over) begin
      w_state_n = ST_HALT;
    end else if (bus.start && (r_state == ST_IDLE || r_state == ST_HALT)) begin
      w_state_n = ST_RUN;
      w_cnt_n   = '0;
      w_spd_n   = bus.speed;
      w_dir_n   = 2'd0;
      w_q0_n    = 2'd0;
      w_q1_n    = 2'd0;
      w_count_n = 2'd0;
    end else if (bus.pause_toggle && r_state == ST_RUN) begin
      w_state_n = ST_PAUSE;
    end else if (bus.pause_toggle && r_state == ST_PAUSE) begin
      w_state_n = ST_RUN;
    end else if (r_state == ST_RUN) begin
      if (r_cnt == w_last) begin
        w_cnt_n  = '0;
        w_tick_n = 1'b1;
        w_spd_n  = bus.speed;
        if (r_count != 2'd0) begin
          w_dir_n   = r_q0;
          w_q0_n    = r_q1;
          w_count_n = r_count - 2'd1;
        end
      end else begin
        w_cnt_n = r_cnt + CNT_W'(1);
      end

      // Turns are filtered against the newest pending direction after this cycle's pop
      if (w_count_n == 2'd0)      w_ref = w_dir_n;
      else if (w_count_n == 2'd1) w_ref = w_q0_n;
      else                        w_ref = w_q1_n;

      if (bus.dir_req_valid && bus.dir_req != w_ref) begin
        if (bus.dir_req == (w_ref ^ 2'b10) || w_count_n == 2'd2) begin
          w_drop_n = 1'b1;
        end else begin
          if (w_count_n == 2'd0) w_q0_n = bus.dir_req;
          else                   w_q1_n = bus.dir_req;
          w_count_n = w_count_n + 2'd1;
        end
      end
    end
  end

  assign bus.move_tick   = r_tick;
  assign bus.move_dir    = r_dir;
  assign bus.queue_count = r_count;
  assign bus.dropped     = r_drop;
  assign bus.state_o     = r_state;

endmodule

// File: tb/tb_move_scheduler.sv
// Bench for move_scheduler with a short tick period: expected ticks are queued with their
// cycle and direction and matched by a monitor; turn filtering is driven from a vector table.
module tb_move_scheduler;
  localparam int unsigned TB_BASE = 10;
  localparam int unsigned TB_STEP = 2;
  localparam int unsigned TB_CW   = 8;

  typedef struct {
    int         cyc;
    logic [1:0] dir;
  } tick_exp_t;

  typedef struct {
    logic [1:0] req;
    logic       exp_drop;
    logic [1:0] exp_cnt;
  } req_vec_t;

  logic clk;
  logic rstn;
  move_scheduler_if bus ();

  move_scheduler #(
    .TICK_BASE(TB_BASE),
    .TICK_STEP(TB_STEP),
    .CNT_W    (TB_CW)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  tick_exp_t sb[$];
  tick_exp_t mon_e;
  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Tick scoreboard: every observed tick must match the head entry in cycle and direction
  always @(posedge clk) begin
    #1;
    if (bus.move_tick) begin
      if (sb.size() == 0) begin
        check("tick_unexpected", 32'(bus.move_tick), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("tick_cycle", 32'(cyc), 32'(mon_e.cyc));
        check("tick_dir", 32'(bus.move_dir), 32'(mon_e.dir));
      end
    end else if (sb.size() != 0 && cyc >= sb[0].cyc) begin
      mon_e = sb.pop_front();
      check("tick_missing", 32'(bus.move_tick), 32'd1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic exp_tick(input int c, input logic [1:0] d);
    tick_exp_t e;
    e.cyc = c;
    e.dir = d;
    sb.push_back(e);
  endtask

  task automatic req(input logic [1:0] d);
    bus.dir_req       = d;
    bus.dir_req_valid = 1'b1;
    step();
    bus.dir_req_valid = 1'b0;
  endtask

  task automatic pulse_start(output int s);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    s = cyc;
  endtask

  task automatic restart(output int s);
    bus.game_over = 1'b1;
    step();
    bus.game_over = 1'b0;
    pulse_start(s);
  endtask

  initial begin
    req_vec_t vecs[8];
    int s;
    int r;

    vecs[0] = '{2'b00, 1'b0, 2'd0};  // same as move_dir: ignored
    vecs[1] = '{2'b10, 1'b1, 2'd0};  // reverse of move_dir
    vecs[2] = '{2'b11, 1'b0, 2'd1};  // accepted
    vecs[3] = '{2'b11, 1'b0, 2'd1};  // same as tail: ignored
    vecs[4] = '{2'b01, 1'b1, 2'd1};  // reverse of tail 11
    vecs[5] = '{2'b10, 1'b0, 2'd2};  // accepted, queue full
    vecs[6] = '{2'b01, 1'b1, 2'd2};  // full
    vecs[7] = '{2'b00, 1'b1, 2'd2};  // reverse of tail 10 and full

    rstn              = 1'b0;
    bus.dir_req       = 2'd0;
    bus.dir_req_valid = 1'b0;
    bus.start         = 1'b0;
    bus.pause_toggle  = 1'b0;
    bus.game_over     = 1'b0;
    bus.speed         = 2'd0;
    repeat (3) step();
    check("rst_state", 32'(bus.state_o), 32'd0);
    check("rst_dir", 32'(bus.move_dir), 32'd0);
    check("rst_count", 32'(bus.queue_count), 32'd0);
    check("rst_tick", 32'(bus.move_tick), 32'd0);
    check("rst_dropped", 32'(bus.dropped), 32'd0);
    rstn = 1'b1;
    repeat (2) step();
    check("idle_hold", 32'(bus.state_o), 32'd0);

    // Basic periodic ticks from IDLE
    pulse_start(s);
    check("t1_state", 32'(bus.state_o), 32'd1);
    check("t1_dir", 32'(bus.move_dir), 32'd0);
    exp_tick(s + 10, 2'd0);
    exp_tick(s + 20, 2'd0);
    exp_tick(s + 30, 2'd0);
    wait_until(s + 30);

    // Two queued turns, then a push on the tick edge with a full queue
    restart(s);
    req(2'b01);
    req(2'b10);
    check("t2_count2", 32'(bus.queue_count), 32'd2);
    exp_tick(s + 10, 2'b01);
    exp_tick(s + 20, 2'b10);
    exp_tick(s + 30, 2'b11);
    wait_until(s + 9);
    bus.dir_req       = 2'b11;
    bus.dir_req_valid = 1'b1;
    step();
    bus.dir_req_valid = 1'b0;
    check("t2_pop_push_count", 32'(bus.queue_count), 32'd2);
    check("t2_pop_push_drop", 32'(bus.dropped), 32'd0);
    wait_until(s + 30);
    check("t2_count0", 32'(bus.queue_count), 32'd0);
    check("t2_dir", 32'(bus.move_dir), 32'd3);

    // Turn filtering table
    restart(s);
    for (int i = 0; i < 8; i++) begin
      req(vecs[i].req);
      check($sformatf("t3_drop_%0d", i), 32'(bus.dropped), 32'(vecs[i].exp_drop));
      check($sformatf("t3_count_%0d", i), 32'(bus.queue_count), 32'(vecs[i].exp_cnt));
    end
    exp_tick(s + 10, 2'b11);
    exp_tick(s + 20, 2'b10);
    wait_until(s + 10);
    check("t3_count_after1", 32'(bus.queue_count), 32'd1);
    wait_until(s + 20);
    check("t3_count_after2", 32'(bus.queue_count), 32'd0);

    // Pause at counter 4, hold, resume
    restart(s);
    req(2'b01);
    wait_until(s + 4);
    bus.pause_toggle = 1'b1;
    step();
    bus.pause_toggle = 1'b0;
    check("t4_paused", 32'(bus.state_o), 32'd2);
    repeat (10) step();
    req(2'b10);
    check("t4_req_drop", 32'(bus.dropped), 32'd0);
    check("t4_req_count", 32'(bus.queue_count), 32'd1);
    repeat (9) step();
    check("t4_state_hold", 32'(bus.state_o), 32'd2);
    check("t4_dir_hold", 32'(bus.move_dir), 32'd0);
    bus.pause_toggle = 1'b1;
    step();
    bus.pause_toggle = 1'b0;
    r = cyc;
    check("t4_resumed", 32'(bus.state_o), 32'd1);
    exp_tick(r + 6, 2'b01);
    exp_tick(r + 16, 2'b01);
    wait_until(r + 16);

    // Speed 3, switched to 0 mid-period
    bus.speed = 2'd3;
    restart(s);
    exp_tick(s + 4, 2'd0);
    exp_tick(s + 8, 2'd0);
    exp_tick(s + 18, 2'd0);
    exp_tick(s + 28, 2'd0);
    wait_until(s + 5);
    bus.speed = 2'd0;
    wait_until(s + 28);
    check("t5_state", 32'(bus.state_o), 32'd1);

    // game_over on a tick edge with a full queue and a same-cycle request
    restart(s);
    req(2'b01);
    req(2'b10);
    wait_until(s + 9);
    bus.game_over     = 1'b1;
    bus.dir_req       = 2'b11;
    bus.dir_req_valid = 1'b1;
    step();
    bus.game_over     = 1'b0;
    bus.dir_req_valid = 1'b0;
    check("t6_halt", 32'(bus.state_o), 32'd3);
    check("t6_count", 32'(bus.queue_count), 32'd2);
    check("t6_dir", 32'(bus.move_dir), 32'd0);
    check("t6_drop", 32'(bus.dropped), 32'd0);
    repeat (15) step();
    req(2'b11);
    check("t6_halt_req_drop", 32'(bus.dropped), 32'd0);
    check("t6_halt_req_count", 32'(bus.queue_count), 32'd2);
    bus.pause_toggle = 1'b1;
    step();
    bus.pause_toggle = 1'b0;
    check("t6_halt_pause", 32'(bus.state_o), 32'd3);
    pulse_start(s);
    check("t6_restart_state", 32'(bus.state_o), 32'd1);
    check("t6_restart_count", 32'(bus.queue_count), 32'd0);
    check("t6_restart_dir", 32'(bus.move_dir), 32'd0);
    req(2'b01);
    exp_tick(s + 10, 2'b01);
    wait_until(s + 10);
    req(2'b10);
    req(2'b11);
    req(2'b00);
    check("t6_pre_rst_drop", 32'(bus.dropped), 32'd1);
    check("t6_pre_rst_count", 32'(bus.queue_count), 32'd2);

    // Asynchronous reset between clock edges
    #2;
    rstn = 1'b0;
    #1;
    check("arst_state", 32'(bus.state_o), 32'd0);
    check("arst_dir", 32'(bus.move_dir), 32'd0);
    check("arst_count", 32'(bus.queue_count), 32'd0);
    check("arst_drop", 32'(bus.dropped), 32'd0);
    check("arst_tick", 32'(bus.move_tick), 32'd0);
    step();
    rstn = 1'b1;
    repeat (3) step();
    check("post_rst_idle", 32'(bus.state_o), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
